// File: rtl/letter_display_scan_if.sv
// Bus between the day-setting stage and the day-of-week display scanner:
// letter codes, load strobe and blink request in, scanned display pins out.
interface letter_display_scan_if;
  logic [3:0] first_letter;
  logic [3:0] second_letter;
  logic [3:0] third_letter;
  logic [3:0] fourth_letter;
  logic       load;
  logic       blink_en;
  logic [3:0] digit_sel_n;
  logic [6:0] seg_n;
  logic       frame_tick;

  modport master (
    output first_letter, second_letter, third_letter, fourth_letter,
    output load, blink_en,
    input  digit_sel_n, seg_n, frame_tick
  );

  modport slave (
    input  first_letter, second_letter, third_letter, fourth_letter,
    input  load, blink_en,
    output digit_sel_n, seg_n, frame_tick
  );
endinterface

// File: rtl/letter_display_scan.sv
// Four-digit multiplexed 7-segment scanner for the day-of-week display.
// Letters are captured into shadow registers on load, scanned one digit
// per SCAN_DIV cycles, and optionally blanked every BLINK_DIV frames.
// All pins come straight from flops so digit and segments switch together.
module letter_display_scan #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  letter_display_scan_if.slave  bus
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_DIV - 1);

  // Letter code to active-high glyph {g,f,e,d,c,b,a}; illegal codes show a dash.
  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'd0:    g = 7'h00; // SPACE
      4'd1:    g = 7'h77; // A
      4'd2:    g = 7'h5E; // D
      4'd3:    g = 7'h79; // E
      4'd4:    g = 7'h71; // F
      4'd5:    g = 7'h76; // H
      4'd6:    g = 7'h06; // I
      4'd7:    g = 7'h54; // N
      4'd8:    g = 7'h3F; // O
      4'd9:    g = 7'h73; // P
      4'd10:   g = 7'h50; // R
      4'd11:   g = 7'h6D; // S
      4'd12:   g = 7'h78; // T
      4'd13:   g = 7'h3E; // U
      default: g = 7'h40; // dash
    endcase
    return g;
  endfunction

  logic [CNT_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [3:0][3:0]    shadow_q, shadow_d;
  logic [BLK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;
  logic               wrap_q, wrap_d;
  logic [3:0]         digit_sel_n_q, digit_sel_n_d;
  logic [6:0]         seg_n_q, seg_n_d;
  logic               frame_tick_q, frame_tick_d;

  logic               scan_done;
  logic               frame_wrap;

  // Next-state for scan position, shadows, blink phase and the output register.
  always_comb begin
    scan_done  = (scan_cnt_q == SCAN_LAST);
    frame_wrap = scan_done && (idx_q == 2'd3);

    scan_cnt_d = scan_done ? '0 : scan_cnt_q + CNT_W'(1);
    idx_d      = scan_done ? idx_q + 2'd1 : idx_q;

    shadow_d = shadow_q;
    if (bus.load) begin
      shadow_d[0] = bus.first_letter;
      shadow_d[1] = bus.second_letter;
      shadow_d[2] = bus.third_letter;
      shadow_d[3] = bus.fourth_letter;
    end

    // Blink counts whole frames; dropping blink_en rearms a visible half.
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (!bus.blink_en) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (frame_wrap) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end

    // wrap_q marks that idx just returned to 0, so the tick lines up with
    // the first output cycle of digit 0 rather than the wrap itself.
    wrap_d       = frame_wrap;
    frame_tick_d = wrap_q;

    // Pins reflect the current idx/shadow; blank follows blink_en directly
    // so releasing it restores segments on the very next edge.
    digit_sel_n_d = ~(4'b0001 << idx_q);
    seg_n_d       = (bus.blink_en && phase_q) ? 7'h7F : ~glyph(shadow_q[idx_q]);
  end

  // State and output registers; reset wins over load, blink and scanning.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_q    <= '0;
      idx_q         <= 2'd0;
      shadow_q      <= '0;
      blink_cnt_q   <= '0;
      phase_q       <= 1'b0;
      wrap_q        <= 1'b0;
      digit_sel_n_q <= 4'b1111;
      seg_n_q       <= 7'h7F;
      frame_tick_q  <= 1'b0;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      blink_cnt_q   <= blink_cnt_d;
      phase_q       <= phase_d;
      wrap_q        <= wrap_d;
      digit_sel_n_q <= digit_sel_n_d;
      seg_n_q       <= seg_n_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign bus.digit_sel_n = digit_sel_n_q;
  assign bus.seg_n       = seg_n_q;
  assign bus.frame_tick  = frame_tick_q;

endmodule
